// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared constants and writeback entry layout for the mult/div issue controller.
package multdiv_pkg;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int MD_LATENCY = 16;
  localparam int MD_TAG_W = 5;
  typedef struct packed {
    logic [31:0] data;
    logic exc;
    logic [MD_TAG_W-1:0] tag;
  } wb_entry_t;
endpackage

// File: rtl/md_result_fifo.sv
// md_result_fifo: synchronous result FIFO; exposes entries in head-first order for tag lookups.
module md_result_fifo
  import multdiv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  input logic i_push,
  input wb_entry_t i_data,
  input logic i_pop,
  output wb_entry_t [DEPTH-1:0] o_ord,
  output logic o_full,
  output logic o_empty,
  output logic [CW-1:0] o_count
);
  wb_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign w_push = i_push & ~o_full;
  assign w_pop = i_pop & ~o_empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  // slot k of o_ord is the k-th oldest entry; only slots below o_count are live
  always_comb begin
    for (int k = 0; k < DEPTH; k++) o_ord[k] = r_mem[r_rd + PW'(k)];
  end
endmodule

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: issues mult/div ops to the pipelined unit, tracks destination tags to the
// result, buffers results for writeback and answers source-register hazard queries.
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int LATENCY = MD_LATENCY,
  parameter int TAG_W = MD_TAG_W,
  parameter int RES_DEPTH = 4,
  localparam int CW = $clog2(RES_DEPTH + 1)
) (
  input logic clock,
  input logic rs,
  input logic req_valid,
  output logic req_ready,
  input logic req_op,
  input logic [31:0] req_a,
  input logic [31:0] req_b,
  input logic [TAG_W-1:0] req_tag,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic md_ctrl_MULT,
  output logic md_ctrl_DIV,
  input logic [31:0] md_result,
  input logic md_exception,
  input logic md_resultRDY,
  output logic wb_valid,
  input logic wb_ready,
  output logic [31:0] wb_data,
  output logic wb_exc,
  output logic [TAG_W-1:0] wb_tag,
  input logic [TAG_W-1:0] hz_rs1,
  input logic [TAG_W-1:0] hz_rs2,
  output logic hz_busy1,
  output logic hz_busy2,
  output logic [CW-1:0] outstanding,
  output logic err_sync
);
  logic w_fire, w_head_v, w_cap, w_miss, w_pop, w_full, w_empty;
  logic [CW-1:0] w_cnt, r_out;
  logic [LATENCY:0] r_dl_v;
  logic [LATENCY:0][TAG_W-1:0] r_dl_tag;
  logic [31:0] r_a, r_b;
  logic r_mult, r_div, r_err;
  wb_entry_t w_push_e;
  wb_entry_t [RES_DEPTH-1:0] w_ord;
  // credits cover both in-flight ops and buffered results, so the FIFO can never overflow
  assign req_ready = r_out < CW'(RES_DEPTH);
  assign w_fire = req_valid & req_ready;
  assign w_head_v = r_dl_v[LATENCY];
  assign w_cap = md_resultRDY & w_head_v;
  assign w_miss = w_head_v & ~md_resultRDY;
  assign w_pop = wb_valid & wb_ready;
  assign w_push_e = '{data: md_result, exc: md_exception, tag: r_dl_tag[LATENCY]};
  assign md_operandA = r_a;
  assign md_operandB = r_b;
  assign md_ctrl_MULT = r_mult;
  assign md_ctrl_DIV = r_div;
  assign outstanding = r_out;
  assign err_sync = r_err;
  assign wb_valid = ~w_empty;
  assign wb_data = w_ord[0].data;
  assign wb_exc = w_ord[0].exc;
  assign wb_tag = w_ord[0].tag;
  always_ff @(posedge clock) begin
    if (rs) begin
      r_a <= '0;
      r_b <= '0;
      r_mult <= 1'b0;
      r_div <= 1'b0;
      r_dl_v <= '0;
      r_dl_tag <= '0;
      r_out <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_fire) begin
        r_a <= req_a;
        r_b <= req_b;
      end
      r_mult <= w_fire & (req_op == OP_MULT);
      r_div <= w_fire & (req_op == OP_DIV);
      r_dl_v <= {r_dl_v[LATENCY-1:0], w_fire};
      r_dl_tag <= {r_dl_tag[LATENCY-1:0], req_tag};
      r_out <= r_out + CW'(w_fire) - CW'(w_pop) - CW'(w_miss);
      r_err <= r_err | (md_resultRDY ^ w_head_v);
    end
  end
  md_result_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
    .clk(clock),
    .rst(rs),
    .i_push(w_cap),
    .i_data(w_push_e),
    .i_pop(w_pop),
    .o_ord(w_ord),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_cnt)
  );
  always_comb begin
    hz_busy1 = 1'b0;
    hz_busy2 = 1'b0;
    for (int i = 0; i <= LATENCY; i++) begin
      hz_busy1 |= r_dl_v[i] & (r_dl_tag[i] == hz_rs1);
      hz_busy2 |= r_dl_v[i] & (r_dl_tag[i] == hz_rs2);
    end
    for (int k = 0; k < RES_DEPTH; k++) begin
      hz_busy1 |= (CW'(k) < w_cnt) & (w_ord[k].tag == hz_rs1);
      hz_busy2 |= (CW'(k) < w_cnt) & (w_ord[k].tag == hz_rs2);
    end
    hz_busy1 &= |hz_rs1;
    hz_busy2 &= |hz_rs2;
  end
endmodule
